// File: rtl/dual_ram_be.sv
// dual_ram_be: single-write, multi-read RAM with byte write enables and
// write-first, byte-granular bypass on every read port.
//
// Optional build macro: DUAL_RAM_OUTREG_EN adds a second output register
// stage (read latency 2 instead of 1).
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset (clears outputs, not memory)
//   wr_en_i     write request
//   wr_addr_i   write word address
//   wr_be_i     byte write enables, bit j covers data[8j+7:8j]
//   wr_data_i   write data
//   rd_en_i     per-port read request
//   rd_addr_i   per-port read address, port k at [k*AW +: AW]
//   rd_data_o   per-port read data, port k at [k*DW +: DW]
//   rd_valid_o  per-port flag, high in the cycle its data is fresh
module dual_ram_be #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 12,
  parameter int unsigned MEM_NUM  = 4096,
  parameter int unsigned RD_PORTS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [AW-1:0]            wr_addr_i,
  input  logic [DW/8-1:0]          wr_be_i,
  input  logic [DW-1:0]            wr_data_i,
  input  logic [RD_PORTS-1:0]      rd_en_i,
  input  logic [RD_PORTS*AW-1:0]   rd_addr_i,
  output logic [RD_PORTS*DW-1:0]   rd_data_o,
  output logic [RD_PORTS-1:0]      rd_valid_o
);

  localparam int unsigned NB = DW / 8;
  // One extra bit so MEM_NUM == 2**AW is representable.
  localparam logic [AW:0] MEM_LIM = (AW+1)'(MEM_NUM);

  logic [DW-1:0] mem [MEM_NUM];

  logic                   wr_ok_c;
  logic [RD_PORTS*DW-1:0] rd_word_c;
  logic [RD_PORTS*DW-1:0] s1_data;
  logic [RD_PORTS-1:0]    s1_valid;

  // A write takes effect only out of reset, in range, with some byte enabled.
  assign wr_ok_c = rst_n && wr_en_i && |wr_be_i && ({1'b0, wr_addr_i} < MEM_LIM);

  // Memory array: no reset, contents undefined until written.
  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      for (int j = 0; j < NB; j++) begin
        if (wr_be_i[j]) begin
          mem[wr_addr_i][j*8 +: 8] <= wr_data_i[j*8 +: 8];
        end
      end
    end
  end

  // Per-port read word: stored data overlaid byte-wise with a same-cycle
  // write to the same address; out-of-range addresses read as zero.
  always_comb begin
    rd_word_c = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      if ({1'b0, rd_addr_i[k*AW +: AW]} < MEM_LIM) begin
        rd_word_c[k*DW +: DW] = mem[rd_addr_i[k*AW +: AW]];
        if (wr_ok_c && (wr_addr_i == rd_addr_i[k*AW +: AW])) begin
          for (int j = 0; j < NB; j++) begin
            if (wr_be_i[j]) begin
              rd_word_c[k*DW + j*8 +: 8] = wr_data_i[j*8 +: 8];
            end
          end
        end
      end
    end
  end

  // First output stage: data slices hold when their port is idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= '0;
    end else begin
      s1_valid <= rd_en_i;
      for (int k = 0; k < RD_PORTS; k++) begin
        if (rd_en_i[k]) begin
          s1_data[k*DW +: DW] <= rd_word_c[k*DW +: DW];
        end
      end
    end
  end

`ifdef DUAL_RAM_OUTREG_EN
  logic [RD_PORTS*DW-1:0] s2_data;
  logic [RD_PORTS-1:0]    s2_valid;

  // Second stage: a plain delay of stage one, so later writes cannot leak in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_data  <= '0;
      s2_valid <= '0;
    end else begin
      s2_data  <= s1_data;
      s2_valid <= s1_valid;
    end
  end

  assign rd_data_o  = s2_data;
  assign rd_valid_o = s2_valid;
`else
  assign rd_data_o  = s1_data;
  assign rd_valid_o = s1_valid;
`endif

endmodule

// File: tb/tb_dual_ram_be.sv
// tb_dual_ram_be: drives two dual_ram_be instances (MEM_NUM 4096 and 3000)
// from shared inputs and compares both against a memory-array model in
// which a read returns the memory as it stands after the same-edge write.
module tb_dual_ram_be;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned RP = 2;
`ifdef DUAL_RAM_OUTREG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  typedef struct packed {
    logic [RP-1:0]    v;
    logic [RP*DW-1:0] d;
  } rec_t;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW/8-1:0]   wr_be;
  logic [DW-1:0]     wr_data;
  logic [RP-1:0]     rd_en;
  logic [RP*AW-1:0]  rd_addr;
  logic [RP*DW-1:0]  rd_data_a;
  logic [RP-1:0]     rd_valid_a;
  logic [RP*DW-1:0]  rd_data_b;
  logic [RP-1:0]     rd_valid_b;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0]    mem_m [2][4096];
  int unsigned      lim_m [2] = '{4096, 3000};
  rec_t             pend  [2];
  logic [RP-1:0]    out_v [2];
  logic [RP*DW-1:0] out_d [2];

  dual_ram_be #(.DW(DW), .AW(AW), .MEM_NUM(4096), .RD_PORTS(RP)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_be_i(wr_be), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a)
  );

  dual_ram_be #(.DW(DW), .AW(AW), .MEM_NUM(3000), .RD_PORTS(RP)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_be_i(wr_be), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model of one rising edge for both instances using the current inputs.
  task automatic model_edge();
    for (int n = 0; n < 2; n++) begin
      rec_t nr;
      rec_t r;
      if (!rst_n) begin
        pend[n]  = '0;
        out_v[n] = '0;
        out_d[n] = '0;
      end else begin
        if (wr_en && (32'(wr_addr) < lim_m[n])) begin
          for (int j = 0; j < DW/8; j++) begin
            if (wr_be[j]) mem_m[n][wr_addr][j*8 +: 8] = wr_data[j*8 +: 8];
          end
        end
        nr.v = rd_en;
        nr.d = '0;
        for (int k = 0; k < RP; k++) begin
          int unsigned a;
          a = 32'(rd_addr[k*AW +: AW]);
          if (a < lim_m[n]) nr.d[k*DW +: DW] = mem_m[n][a];
        end
        if (LAT == 2) begin
          r       = pend[n];
          pend[n] = nr;
        end else begin
          r = nr;
        end
        out_v[n] = r.v;
        for (int k = 0; k < RP; k++) begin
          if (r.v[k]) out_d[n][k*DW +: DW] = r.d[k*DW +: DW];
        end
      end
    end
  endtask

  // One clock: model the edge, then sample DUT outputs at the falling edge.
  task automatic step(input bit chk);
    model_edge();
    @(negedge clk);
    if (chk) begin
      check("valid_big",   64'(rd_valid_a), 64'(out_v[0]));
      check("data_big",    64'(rd_data_a),  64'(out_d[0]));
      check("valid_small", 64'(rd_valid_b), 64'(out_v[1]));
      check("data_small",  64'(rd_data_b),  64'(out_d[1]));
    end
  endtask

  task automatic idle();
    rst_n = 1'b1;
    wr_en = 1'b0;
    wr_be = '0;
    rd_en = '0;
  endtask

  task automatic drain();
    for (int i = 1; i < LAT; i++) begin
      idle();
      step(1'b1);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_be   = be;
    wr_data = d;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int unsigned sel;
    sel = $urandom_range(0, 3);
    if (sel < 2)       return AW'($urandom_range(0, 15));
    else if (sel == 2) return AW'($urandom_range(2990, 3010));
    else               return AW'($urandom);
  endfunction

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_be   = '0;
    wr_data = '0;
    rd_en   = '0;
    rd_addr = '0;
    for (int i = 0; i < 3; i++) step(1'b1);

    // Fill memory so every in-range read has a defined model value.
    idle();
    for (int a = 0; a < 4096; a++) begin
      do_write(AW'(a), 4'hF, $urandom);
      step(1'b0);
    end

    // Full write then a read on port 0.
    idle(); do_write(AW'(5), 4'hF, 32'hDEADBEEF); step(1'b1);
    idle(); rd_en = 2'b01; rd_addr = {AW'(0), AW'(5)}; step(1'b1);
    drain();
    check("req032_data",  64'(rd_data_a[31:0]), 64'h0000_0000_DEAD_BEEF);
    check("req032_valid", 64'(rd_valid_a), 64'h1);

    // Partial write with same-cycle read on both ports.
    idle(); do_write(AW'(7), 4'hF, 32'h11223344); step(1'b1);
    idle(); do_write(AW'(7), 4'h5, 32'hAABBCCDD);
    rd_en = 2'b11; rd_addr = {AW'(7), AW'(7)}; step(1'b1);
    drain();
    check("req033_both", 64'(rd_data_a), 64'h11BB33DD_11BB33DD);

    // Top address bypass on port 1; port 0 holds.
    idle(); do_write(AW'(4095), 4'hF, 32'h0);
    rd_en = 2'b10; rd_addr = {AW'(4095), AW'(0)}; step(1'b1);
    drain();
    check("req034_hold", 64'(rd_data_a), 64'h00000000_11BB33DD);

    // Out-of-range on the small instance.
    idle(); do_write(AW'(3500), 4'hF, 32'h12345678); step(1'b1);
    idle(); rd_en = 2'b01; rd_addr = {AW'(0), AW'(3500)}; step(1'b1);
    drain();
    check("req035_zero",  64'(rd_data_b[31:0]), 64'h0);
    check("req035_valid", 64'(rd_valid_b), 64'h1);
    check("req035_big",   64'(rd_data_a[31:0]), 64'h12345678);

    // Reset right after a read.
    idle(); rd_en = 2'b11; rd_addr = {AW'(5), AW'(7)}; step(1'b1);
    idle(); rst_n = 1'b0; rd_en = 2'b11; step(1'b1);
    idle(); rst_n = 1'b0; step(1'b1);
    for (int i = 0; i < 3; i++) begin idle(); step(1'b1); end
    check("req036_valid", 64'(rd_valid_a), 64'h0);
    check("req036_data",  64'(rd_data_a), 64'h0);

    // Read followed by a write to the same address, then a re-read.
    idle(); do_write(AW'(9), 4'hF, 32'h1); step(1'b1);
    idle(); rd_en = 2'b01; rd_addr = {AW'(0), AW'(9)}; step(1'b1);
    idle(); do_write(AW'(9), 4'hF, 32'h2); step(1'b1);
    drain();
    idle(); rd_en = 2'b01; rd_addr = {AW'(0), AW'(9)}; step(1'b1);
    drain();
    check("req037_new", 64'(rd_data_a[31:0]), 64'h2);

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 3000; c++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = rand_addr();
      wr_be   = 4'($urandom);
      wr_data = $urandom;
      rd_en   = 2'($urandom);
      for (int k = 0; k < RP; k++) begin
        rd_addr[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? wr_addr : rand_addr();
      end
      step(1'b1);
    end

    idle();
    step(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_ram_be.md
DUAL_RAM_BE -- requirements
Module: dual_ram_be

Interface
REQ-001 SHALL have parameter DW, default 32: data width in bits, a multiple of 8.
REQ-002 SHALL have parameter AW, default 12: address width.
REQ-003 SHALL have parameter MEM_NUM, default 4096: number of words, at most 2**AW.
REQ-004 SHALL have parameter RD_PORTS, default 2: number of independent read ports, 1..4.
REQ-005 clk  in  1  clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 wr_en_i  in  1  write request.
REQ-008 wr_addr_i  in  AW  write word address.
REQ-009 wr_be_i  in  DW/8  byte write enables; bit j covers data[8j+7:8j].
REQ-010 wr_data_i  in  DW  write data.
REQ-011 rd_en_i  in  RD_PORTS  per-port read request.
REQ-012 rd_addr_i  in  RD_PORTS*AW  per-port address; port k occupies [k*AW +: AW].
REQ-013 rd_data_o  out  RD_PORTS*DW  per-port read data; port k occupies [k*DW +: DW].
REQ-014 rd_valid_o  out  RD_PORTS  per-port flag; high when rd_data_o slice is fresh.

Function
REQ-015 The write SHALL update only the bytes with wr_be_i=1 at the rising edge where wr_en_i=1 and wr_addr_i<MEM_NUM; all other bytes are preserved.
REQ-016 A write with wr_addr_i>=MEM_NUM or with wr_be_i all zero SHALL leave memory unchanged.
REQ-017 A read on port k issued in cycle T SHALL present data in cycle T+1, with rd_valid_o[k]=1 in cycle T+1 only.
REQ-018 When the write and a port-k read in the same cycle target the same address, each byte with wr_be_i=1 SHALL return the new wr_data_i byte, and each other byte SHALL return the stored byte (write-first, byte-granular bypass).
REQ-019 Bypass SHALL be evaluated independently per port; any number of ports may hit the write address simultaneously.
REQ-020 A read with address >=MEM_NUM SHALL return all zeros with rd_valid_o[k]=1.
REQ-021 When rd_en_i[k]=0, rd_data_o slice k SHALL hold its last value and rd_valid_o[k] SHALL be 0.
REQ-022 Reads on different ports to the same address in the same cycle SHALL return identical data.
REQ-023 No combinational path SHALL exist from any input to rd_data_o or rd_valid_o.

Reset
REQ-024 While rst_n=0 at a rising edge, rd_data_o SHALL become all zeros and rd_valid_o SHALL become 0.
REQ-025 While rst_n=0, writes SHALL be suppressed, and reads issued in that cycle SHALL NOT produce rd_valid_o in the following cycle.
REQ-026 Memory contents SHALL NOT be cleared by reset; contents are undefined until written.
REQ-027 Reset asserted mid-pipeline SHALL discard all in-flight reads; no rd_valid_o pulse is emitted for them after reset deasserts.

Configuration
REQ-028 Macro DUAL_RAM_OUTREG_EN, when defined, SHALL add one output register stage, giving read latency 2 cycles; rd_valid_o and rd_data_o are delayed together.
REQ-029 With DUAL_RAM_OUTREG_EN defined, the returned data SHALL reflect memory plus same-cycle bypass as of the read cycle T; a write in T+1 to the same address SHALL NOT alter the data output in T+2.
REQ-030 With DUAL_RAM_OUTREG_EN undefined, latency SHALL be exactly 1 cycle per REQ-017.
REQ-031 The reset values in REQ-024 SHALL apply to both stages when DUAL_RAM_OUTREG_EN is defined.

Verification
REQ-032 Write 0xDEADBEEF to addr 5 with be=0xF, then read port0 addr 5 -> rd_data_o[31:0]=0xDEADBEEF, rd_valid_o=01 one cycle later.
REQ-033 Addr 7 holds 0x11223344; in the same cycle, write 0xAABBCCDD with be=0x5 and read addr 7 on both ports -> both ports return 0x11BB33DD.
REQ-034 Read addr 4095 on port1 while writing addr 4095, be=0xF, data 0x0 -> port1 returns 0x00000000 and port0 slice holds its prior value.
REQ-035 MEM_NUM=3000: write addr 3500, then read addr 3500 -> returns 0 with valid=1, and memory at addr 3500 mod 2**AW is unchanged.
REQ-036 Issue reads in cycle T and assert rst_n=0 in T+1 -> rd_valid_o stays 0 through reset and after release, and rd_data_o=0.
REQ-037 With DUAL_RAM_OUTREG_EN: read addr 9 (holding 0x1) in T and write 0x2 to addr 9 in T+1 -> data 0x1 with valid in T+2; a read in T+2 returns 0x2 in T+4.
